// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and decode-side queue head.
// master = fetch unit, slave = memory/decode side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests, small instruction FIFO.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect sets sticky misalign_err and halts fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic [31:0]  pc_plus4,
  output logic         misalign_err,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] DROP = 3'd3;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [2:0] HALT = 3'd4;
`endif

  logic [2:0]      state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]     buf_pc_q   [BUF_DEPTH];
  logic [31:0]     buf_data_q [BUF_DEPTH];

  logic        fire, push, pop, halted, bad_target;
  logic [31:0] redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redirect_tgt = redirect_pc;
  assign bad_target   = redirect_pc[1:0] != 2'b00;
  assign halted       = state_q == HALT;
  assign misalign_d   = misalign_q | (redirect & bad_target);
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  logic unused_low_bits;

  // Without the check, targets are silently word-aligned.
  assign redirect_tgt    = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];
  assign bad_target      = 1'b0;
  assign halted          = 1'b0;
  assign misalign_err    = 1'b0;
`endif

  assign pc_plus4       = fetch_pc_q + 32'd4;
  assign bus.imem_req   = (state_q == REQ) && (count_q < Depth);
  assign bus.imem_addr  = fetch_pc_q;
  assign fire           = bus.imem_req & bus.imem_gnt;

  assign bus.inst_valid = (count_q != '0) && !redirect;
  assign bus.inst_pc    = buf_pc_q[rd_ptr_q];
  assign bus.inst_data  = buf_data_q[rd_ptr_q];
  assign pop            = bus.inst_valid & bus.inst_ready;
  assign push           = (state_q == WAIT) && bus.imem_rvalid && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (fire) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT, DROP: if (bus.imem_rvalid) state_d = REQ;
      default: ;
    endcase

    // Redirect overrides the sequential path; a granted-but-unreturned request must be dropped.
    if (redirect && !halted) begin
      fetch_pc_d = redirect_tgt;
      case (state_q)
        REQ:        state_d = fire ? DROP : REQ;
        WAIT, DROP: state_d = bus.imem_rvalid ? REQ : DROP;
        default:    state_d = REQ;
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      if (bad_target) state_d = HALT;
`endif
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible once count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
      buf_data_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven sequential fetch plus redirect/backpressure/wrap
// sequences, with an in-order scoreboard of granted addresses checked against decode pops.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb[$];
  logic [31:0] popped[$];
  logic [31:0] fires_q[$];
  bit          pend;
  logic [31:0] pend_addr;
  bit          gnt_en, rv_en;

  typedef struct {
    bit          gnt;
    bit          rv;
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_pp4;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive the memory model for this cycle, then observe what the coming edge will do.
  task automatic sample();
    logic [63:0] e;
    logic        fire;
    bus.imem_gnt    = gnt_en;
    bus.imem_rvalid = pend && rv_en;
    bus.imem_rdata  = pend ? word(pend_addr) : 32'h0;
    #1;
    if (redirect) check("valid_in_redirect", {31'b0, bus.inst_valid}, 32'h0);
    if (bus.inst_valid && bus.inst_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_underflow: got pc %h, expected no word", bus.inst_pc);
      end else begin
        e = sb.pop_front();
        check("inst_pc", bus.inst_pc, e[63:32]);
        check("inst_data", bus.inst_data, e[31:0]);
      end
      popped.push_back(bus.inst_pc);
    end
    if (redirect) sb.delete();
    fire = bus.imem_req && bus.imem_gnt;
    if (fire) begin
      check("single_outstanding", {31'b0, pend && !bus.imem_rvalid}, 32'h0);
      fires_q.push_back(bus.imem_addr);
      if (!redirect) sb.push_back({bus.imem_addr, word(bus.imem_addr)});
    end
    if (bus.imem_rvalid) pend = 1'b0;
    if (fire) begin
      pend      = 1'b1;
      pend_addr = bus.imem_addr;
    end
  endtask

  task automatic step();
    sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    bus.inst_ready = 1'b1;
    bus.imem_gnt   = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    gnt_en = 1'b1;
    rv_en  = 1'b1;
    pend   = 1'b0;
    sb.delete();
    popped.delete();
    fires_q.delete();
    #1;
    check("rst_req", {31'b0, bus.imem_req}, 32'h0);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           gnt rv rdy req addr    valid pc      pp4
    vecs[0] = '{1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h4};
    vecs[1] = '{1, 1, 1, 1, 32'h0, 0, 32'h0, 32'h4};
    vecs[2] = '{1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h8};
    vecs[3] = '{1, 1, 1, 1, 32'h4, 1, 32'h0, 32'h8};
    vecs[4] = '{1, 1, 1, 0, 32'h0, 0, 32'h0, 32'hC};
    vecs[5] = '{1, 1, 1, 1, 32'h8, 1, 32'h4, 32'hC};
    vecs[6] = '{1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h10};
    vecs[7] = '{1, 1, 1, 1, 32'hC, 1, 32'h8, 32'h10};

    // Sequential fetch from reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      gnt_en = vecs[i].gnt;
      rv_en  = vecs[i].rv;
      bus.inst_ready = vecs[i].rdy;
      sample();
      check($sformatf("seq_req[%0d]", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req) check($sformatf("seq_addr[%0d]", i), bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("seq_valid[%0d]", i), {31'b0, bus.inst_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check($sformatf("seq_pc[%0d]", i), bus.inst_pc, vecs[i].exp_pc);
      check($sformatf("seq_pp4[%0d]", i), pc_plus4, vecs[i].exp_pp4);
      @(negedge clk);
    end

    // Backpressure: two words fill the buffer, then fetch stalls until decode drains.
    do_reset();
    bus.inst_ready = 1'b0;
    repeat (12) step();
    sample();
    check("bp_fire_count", 32'(fires_q.size()), 32'd2);
    check("bp_fire0", fires_q[0], 32'h0);
    check("bp_fire1", fires_q[1], 32'h4);
    check("bp_req_stalled", {31'b0, bus.imem_req}, 32'h0);
    check("bp_head_pc", bus.inst_pc, 32'h0);
    @(negedge clk);
    bus.inst_ready = 1'b1;
    fires_q.delete();
    repeat (16) step();
    check("bp_resume_addr", fires_q[0], 32'h8);
    check("bp_pops", {31'b0, popped.size() >= 3}, 32'h1);
    check("bp_pop2", popped[2], 32'h8);

    // Redirect while waiting, response not yet back: old response dropped.
    do_reset();
    repeat (4) step();
    rv_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    sample();
    check("wait_redir_req", {31'b0, bus.imem_req}, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    rv_en = 1'b1;
    sample();
    check("drop_req", {31'b0, bus.imem_req}, 32'h0);
    @(negedge clk);
    popped.delete();
    sample();
    check("drop_next_req", {31'b0, bus.imem_req}, 32'h1);
    check("drop_next_addr", bus.imem_addr, 32'h100);
    @(negedge clk);
    repeat (6) step();
    check("drop_first_pc", popped[0], 32'h100);

    // Redirect on the grant cycle, then redirect coinciding with rvalid.
    do_reset();
    bus.inst_ready = 1'b0;
    step();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    sample();
    check("gnt_redir_req", {31'b0, bus.imem_req}, 32'h1);
    @(negedge clk);
    redirect = 1'b0;
    sample();
    check("gnt_drop_req", {31'b0, bus.imem_req}, 32'h0);
    @(negedge clk);
    sample();
    check("gnt_next_addr", bus.imem_addr, 32'h200);
    @(negedge clk);
    step();
    sample();
    check("gnt_head_valid", {31'b0, bus.inst_valid}, 32'h1);
    check("gnt_head_pc", bus.inst_pc, 32'h200);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    sample();
    @(negedge clk);
    redirect = 1'b0;
    sample();
    check("rv_redir_empty", {31'b0, bus.inst_valid}, 32'h0);
    check("rv_redir_req", {31'b0, bus.imem_req}, 32'h1);
    check("rv_redir_addr", bus.imem_addr, 32'h300);
    @(negedge clk);
    popped.delete();
    bus.inst_ready = 1'b1;
    repeat (6) step();
    check("rv_redir_first_pc", popped[0], 32'h300);

    // Address wrap at the top of the space.
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sample();
    @(negedge clk);
    redirect = 1'b0;
    sample();
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check("wrap_pp4", pc_plus4, 32'h0);
    @(negedge clk);
    sample();
    check("wrap_pp4_next", pc_plus4, 32'h4);
    @(negedge clk);
    sample();
    check("wrap_next_addr", bus.imem_addr, 32'h0);
    check("wrap_pop_pc", popped[0], 32'hFFFF_FFFC);
    @(negedge clk);

    // Misaligned redirect target.
    do_reset();
    gnt_en = 1'b0;
    step();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    sample();
    @(negedge clk);
    redirect = 1'b0;
    gnt_en = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      sample();
      check($sformatf("halt_req[%0d]", i), {31'b0, bus.imem_req}, 32'h0);
      check($sformatf("halt_err[%0d]", i), {31'b0, misalign_err}, 32'h1);
      check($sformatf("halt_valid[%0d]", i), {31'b0, bus.inst_valid}, 32'h0);
      @(negedge clk);
    end
    do_reset();
    step();
`else
    sample();
    check("align_req", {31'b0, bus.imem_req}, 32'h1);
    check("align_addr", bus.imem_addr, 32'h100);
    check("align_err", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    repeat (4) step();
    check("align_pop_pc", popped[0], 32'h100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
